// File: rtl/signal_extension_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : signal_extension_unit_if
//  Description : Operand bus between an instruction decoder and the
//                signal_extension_unit. The master supplies the raw operand
//                field and mode; the slave returns the extended operand on
//                both a combinational and a registered path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface signal_extension_unit_if #(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 16
) ();

    logic [IN_WIDTH-1:0]  inst_operand;
    logic                 ext_mode;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] out_operand;
    logic [OUT_WIDTH-1:0] out_operand_r;
    logic                 out_valid;

    // Decoder side: drives the operand field, consumes the extended results.
    modport master (
        output inst_operand,
        output ext_mode,
        output in_valid,
        input  out_operand,
        input  out_operand_r,
        input  out_valid
    );

    // Extension unit side.
    modport slave (
        input  inst_operand,
        input  ext_mode,
        input  in_valid,
        output out_operand,
        output out_operand_r,
        output out_valid
    );

endinterface : signal_extension_unit_if
`default_nettype wire

// File: rtl/signal_extension_unit.sv
`default_nettype none
// ============================================================================
//  Module      : signal_extension_unit
//  Description : Widens an IN_WIDTH instruction operand to OUT_WIDTH by sign
//                extension (ext_mode=0) or zero extension (ext_mode=1).
//                The extended value is offered combinationally and, when
//                in_valid is high, captured into a one-cycle register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module signal_extension_unit #(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 16   // must exceed IN_WIDTH
) (
    input  wire                      clk,
    input  wire                      reset,
    signal_extension_unit_if.slave   bus
);

    localparam int c_EXT_BITS = OUT_WIDTH - IN_WIDTH;

    logic [c_EXT_BITS-1:0] w_ext_bits;
    logic [OUT_WIDTH-1:0]  w_extended;
    logic [OUT_WIDTH-1:0]  r_operand;
    logic                  r_valid;

    // Upper fill bits: replicated operand MSB for sign mode, zeros otherwise.
    // The low operand bits pass through untouched in both modes.
    always_comb begin
        w_ext_bits = '0;
        if (!bus.ext_mode) begin
            w_ext_bits = {c_EXT_BITS{bus.inst_operand[IN_WIDTH-1]}};
        end
        w_extended = {w_ext_bits, bus.inst_operand};
    end

    // Capture the extended operand on qualified edges; the valid flag is a
    // single-cycle pulse per accepted sample and reset drops any sample in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_operand <= '0;
            r_valid   <= 1'b0;
        end else if (bus.in_valid) begin
            r_operand <= w_extended;
            r_valid   <= 1'b1;
        end else begin
            r_valid   <= 1'b0;
        end
    end

    // The combinational result bypasses clock and reset entirely.
    assign bus.out_operand   = w_extended;
    assign bus.out_operand_r = r_operand;
    assign bus.out_valid     = r_valid;

endmodule : signal_extension_unit
`default_nettype wire

// File: tb/tb_signal_extension_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signal_extension_unit
//  Description : Self-checking bench for signal_extension_unit: directed
//                boundary vectors followed by randomized traffic, compared
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_extension_unit;

    localparam int IN_W  = 11;
    localparam int OUT_W = 16;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    // Reference state for the registered path.
    logic [OUT_W-1:0] exp_r;
    logic             exp_v;

    signal_extension_unit_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

    signal_extension_unit #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock held low long enough for the pre-edge combinational checks.
    initial begin
        clk = 1'b0;
        #50;
        forever #5 clk = ~clk;
    end

    // Extension as arithmetic: a negative operand in sign mode is its value
    // plus 2^OUT - 2^IN (two's complement re-encoding at the wider width).
    function automatic logic [OUT_W-1:0] model_ext(input logic [IN_W-1:0] op,
                                                    input logic mode);
        longint unsigned v;
        v = longint'(op);
        if (!mode && (v >= (64'd1 << (IN_W - 1))))
            v = v + (64'd1 << OUT_W) - (64'd1 << IN_W);
        return v[OUT_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, check the combinational output at once (no edge), then
    // cross one rising edge and check the registered outputs.
    task automatic step(input logic rst_i, input logic vld_i,
                        input logic [IN_W-1:0] op_i, input logic mode_i,
                        input string tag);
        @(negedge clk);
        reset            = rst_i;
        bus.in_valid     = vld_i;
        bus.inst_operand = op_i;
        bus.ext_mode     = mode_i;
        #1;
        check({tag, "_comb"}, bus.out_operand, model_ext(op_i, mode_i));
        @(posedge clk);
        if (rst_i) begin
            exp_r = '0;
            exp_v = 1'b0;
        end else if (vld_i) begin
            exp_r = model_ext(op_i, mode_i);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        check({tag, "_reg"}, bus.out_operand_r, exp_r);
        check({tag, "_vld"}, {{(OUT_W-1){1'b0}}, bus.out_valid},
              {{(OUT_W-1){1'b0}}, exp_v});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_r       = '0;
        exp_v       = 1'b0;

        // Before any clock edge, with reset asserted: combinational path only.
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.ext_mode     = 1'b0;
        bus.inst_operand = 11'h000;
        #1 check("zero_sign", bus.out_operand, 16'h0000);
        bus.inst_operand = 11'h58E;
        #1 check("neg_58e", bus.out_operand, 16'hFD8E);
        bus.inst_operand = 11'h18E;
        #1 check("pos_18e", bus.out_operand, 16'h018E);
        bus.inst_operand = 11'h3FF;
        #1 check("most_pos", bus.out_operand, 16'h03FF);
        bus.inst_operand = 11'h400;
        #1 check("most_neg", bus.out_operand, 16'hFC00);
        bus.inst_operand = 11'h7FF;
        #1 check("all_ones", bus.out_operand, 16'hFFFF);
        bus.ext_mode     = 1'b1;
        bus.inst_operand = 11'h58E;
        #1 check("zero_ext_58e", bus.out_operand, 16'h058E);

        // Reset wins over a simultaneous valid sample.
        step(1'b1, 1'b1, 11'h58E, 1'b0, "rst_with_valid");
        check("rst_reg_const", bus.out_operand_r, 16'h0000);
        // First sample after release, then an idle edge that must hold data.
        step(1'b0, 1'b1, 11'h58E, 1'b0, "first_valid");
        check("first_valid_const", bus.out_operand_r, 16'hFD8E);
        step(1'b0, 1'b0, 11'h123, 1'b1, "idle_hold");
        check("idle_hold_const", bus.out_operand_r, 16'hFD8E);
        // Mid-stream reset discards the in-flight sample.
        step(1'b0, 1'b1, 11'h7FF, 1'b1, "pre_reset");
        step(1'b1, 1'b1, 11'h400, 1'b0, "mid_reset");
        step(1'b0, 1'b1, 11'h400, 1'b0, "post_reset");

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 IN_W'($urandom),
                 1'($urandom_range(0, 1)),
                 "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_signal_extension_unit
`default_nettype wire

// File: doc/signal_extension_unit.md
SIGNAL_EXTENSION_UNIT -- requirements
Module: signal_extension_unit

Interface
REQ-001 Parameter IN_WIDTH, default 11, width of the instruction operand field.
REQ-002 Parameter OUT_WIDTH, default 16, width of the extended datapath operand; SHALL be greater than IN_WIDTH.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for the registered path.
REQ-005 reset  input  1  synchronous, active-high reset of all registers.
REQ-006 inst_operand  input  IN_WIDTH  operand field of the current instruction.
REQ-007 ext_mode  input  1  0 = sign extension (default usage, tie low), 1 = zero extension.
REQ-008 in_valid  input  1  qualifies inst_operand for the registered path.
REQ-009 out_operand  output  OUT_WIDTH  combinational extended operand.
REQ-010 out_operand_r  output  OUT_WIDTH  registered extended operand.
REQ-011 out_valid  output  1  qualifies out_operand_r.

Function
REQ-012 out_operand SHALL be purely combinational from inst_operand and ext_mode, zero-cycle latency, independent of clk and reset.
REQ-013 ext_mode=0: out_operand[IN_WIDTH-1:0] = inst_operand; bits [OUT_WIDTH-1:IN_WIDTH] all equal inst_operand[IN_WIDTH-1].
REQ-014 ext_mode=1: out_operand[IN_WIDTH-1:0] = inst_operand; bits [OUT_WIDTH-1:IN_WIDTH] all 0.
REQ-015 Low IN_WIDTH bits SHALL never be modified by either mode.
REQ-016 Sign-mode boundaries: most-positive input (MSB 0, rest 1) -> upper bits 0; most-negative input (MSB 1, rest 0) -> upper bits 1.
REQ-017 On each rising clk edge with reset low and in_valid high: out_operand_r <= current out_operand value; out_valid <= 1.
REQ-018 On each rising clk edge with reset low and in_valid low: out_operand_r holds; out_valid <= 0.
REQ-019 Registered-path latency SHALL be exactly one clock cycle from in_valid sample to out_valid.
REQ-020 Changes of ext_mode or inst_operand between edges SHALL affect out_operand immediately and out_operand_r only at the next qualifying edge.
REQ-021 No X propagation: out_operand SHALL be fully defined for every defined input combination.

Reset
REQ-022 On a rising clk edge with reset high: out_operand_r <= 0, out_valid <= 0, regardless of in_valid.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight sample; first valid output after reset release appears one cycle after the first in_valid edge sampled with reset low.
REQ-024 Reset SHALL NOT affect out_operand (combinational path).
REQ-025 Before the first clk edge, out_operand SHALL already reflect inputs.

Verification
REQ-026 ext_mode=0, inst_operand=11'h000 -> out_operand=16'h0000.
REQ-027 ext_mode=0, inst_operand=11'b10110001110 (0x58E) -> out_operand=16'hFD8E; then 11'b00110001110 (0x18E) -> 16'h018E, each without any clock edge.
REQ-028 ext_mode=0: inst_operand=0x3FF -> 16'h03FF; 0x400 -> 16'hFC00; 0x7FF -> 16'hFFFF.
REQ-029 ext_mode=1, inst_operand=0x58E -> out_operand=16'h058E.
REQ-030 reset high one edge, then in_valid=1 with 0x58E at edge N -> out_operand_r=16'hFD8E, out_valid=1 after edge N; in_valid=0 at edge N+1 -> out_valid=0, out_operand_r stays 16'hFD8E.
REQ-031 in_valid=1 and reset=1 on same edge -> out_operand_r=16'h0000, out_valid=0.
